// File: rtl/lmsm_mem_sequencer_if.sv
// Request, memory-bus and writeback signals shared between the MEM stage and
// the LM/SM sequencer. The sequencer connects through the slave modport.
interface lmsm_mem_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
);
    localparam int IDX_W = $clog2(NREG);

    logic              in_valid;
    logic [1:0]        in_op;
    logic [NREG-1:0]   in_mask;
    logic [ADDR_W-1:0] in_base;
    logic              in_flush;
    logic              mem_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [IDX_W-1:0]  sm_reg_sel;
    logic [IDX_W-1:0]  out_RDest;
    logic              out_W_reg;
    logic              out_Validity;
    logic              stall_MEM;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_op, in_mask, in_base, in_flush, mem_ready,
        input  mem_addr, mem_rd, mem_wr, sm_reg_sel, out_RDest, out_W_reg,
               out_Validity, stall_MEM, busy, done, err
    );

    modport slave (
        input  in_valid, in_op, in_mask, in_base, in_flush, mem_ready,
        output mem_addr, mem_rd, mem_wr, sm_reg_sel, out_RDest, out_W_reg,
               out_Validity, stall_MEM, busy, done, err
    );
endinterface

// File: rtl/lmsm_mem_sequencer.sv
// Walks an LM/SM register mask in the MEM stage, issuing one memory access per
// set bit at consecutive addresses while holding MEM/WB through stall_MEM.
module lmsm_mem_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int NREG     = 8,
    parameter int MAX_WAIT = 255
) (
    input logic                 clk,
    input logic                 resetn,
    lmsm_mem_sequencer_if.slave bus
);
    localparam int         IDX_W = $clog2(NREG);
    localparam int         CNT_W = 8;
    localparam logic [1:0] OP_LM = 2'b01;
    localparam logic [1:0] OP_SM = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q, state_n;
    logic [NREG-1:0]   mask_q, mask_n;
    logic              lm_q, lm_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              rd_q, rd_n;
    logic              wr_q, wr_n;
    logic [IDX_W-1:0]  sel_q, sel_n;
    logic [IDX_W-1:0]  rdest_q, rdest_n;
    logic              wb_q, wb_n;
    logic              active_q, active_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic [NREG-1:0]   remain;
    logic              start_op;
    logic              to_idle;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREG-1:0] m);
        lowest_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    assign remain   = mask_q & (mask_q - NREG'(1));
    assign start_op = (bus.in_op == OP_LM) || (bus.in_op == OP_SM);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            lm_q     <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            sel_q    <= '0;
            rdest_q  <= '0;
            wb_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            mask_q   <= mask_n;
            lm_q     <= lm_n;
            cnt_q    <= cnt_n;
            addr_q   <= addr_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            sel_q    <= sel_n;
            rdest_q  <= rdest_n;
            wb_q     <= wb_n;
            active_q <= active_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    // Flush outranks mem_ready; a timeout drops the pending element without writeback.
    always_comb begin
        state_n  = state_q;
        mask_n   = mask_q;
        lm_n     = lm_q;
        cnt_n    = cnt_q;
        addr_n   = addr_q;
        rd_n     = rd_q;
        wr_n     = wr_q;
        sel_n    = sel_q;
        rdest_n  = rdest_q;
        wb_n     = 1'b0;
        active_n = active_q;
        done_n   = 1'b0;
        err_n    = err_q;
        to_idle  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && !bus.in_flush && start_op) begin
                    if (bus.in_mask != '0) begin
                        state_n  = ACCESS;
                        mask_n   = bus.in_mask;
                        lm_n     = (bus.in_op == OP_LM);
                        cnt_n    = '0;
                        addr_n   = bus.in_base;
                        rd_n     = (bus.in_op == OP_LM);
                        wr_n     = (bus.in_op == OP_SM);
                        sel_n    = lowest_idx(bus.in_mask);
                        active_n = 1'b1;
                        err_n    = 1'b0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (bus.in_flush) begin
                    to_idle = 1'b1;
                end else if (bus.mem_ready) begin
                    mask_n = remain;
                    cnt_n  = '0;
                    wb_n   = lm_q;
                    if (lm_q) rdest_n = lowest_idx(mask_q);
                    if (remain != '0) begin
                        addr_n = addr_q + ADDR_W'(1);
                        sel_n  = lowest_idx(remain);
                    end else begin
                        to_idle = 1'b1;
                        done_n  = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    to_idle = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: to_idle = 1'b1;
        endcase

        if (to_idle) begin
            state_n  = IDLE;
            mask_n   = '0;
            cnt_n    = '0;
            addr_n   = '0;
            rd_n     = 1'b0;
            wr_n     = 1'b0;
            sel_n    = '0;
            active_n = 1'b0;
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.mem_rd       = rd_q;
    assign bus.mem_wr       = wr_q;
    assign bus.sm_reg_sel   = sel_q;
    assign bus.out_RDest    = rdest_q;
    assign bus.out_W_reg    = wb_q;
    assign bus.out_Validity = wb_q;
    assign bus.stall_MEM    = active_q;
    assign bus.busy         = active_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_lmsm_mem_sequencer.sv
// Self-checking bench for lmsm_mem_sequencer: directed scenarios plus random
// LM/SM transactions checked against a per-element transaction model.
module tb_lmsm_mem_sequencer;
    localparam logic [1:0] OP_LM = 2'b01;
    localparam logic [1:0] OP_SM = 2'b10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_err = 1'b0;

    lmsm_mem_sequencer_if bus ();

    lmsm_mem_sequencer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_addr"},  32'(bus.mem_addr), 32'(0));
        check({tag, ".mem_rd"},    32'(bus.mem_rd), 32'(0));
        check({tag, ".mem_wr"},    32'(bus.mem_wr), 32'(0));
        check({tag, ".sm_reg_sel"}, 32'(bus.sm_reg_sel), 32'(0));
        check({tag, ".RDest"},     32'(bus.out_RDest), 32'(0));
        check({tag, ".W_reg"},     32'(bus.out_W_reg), 32'(0));
        check({tag, ".Validity"},  32'(bus.out_Validity), 32'(0));
        check({tag, ".stall"},     32'(bus.stall_MEM), 32'(0));
        check({tag, ".busy"},      32'(bus.busy), 32'(0));
        check({tag, ".done"},      32'(bus.done), 32'(0));
        check({tag, ".err"},       32'(bus.err), 32'(0));
    endtask

    task automatic check_output(input string tag, input logic e_busy, input logic e_rd,
                                input logic e_wr, input logic [15:0] e_addr, input logic [2:0] e_sel,
                                input logic e_done, input logic e_wb, input logic [2:0] e_rdest);
        check({tag, ".busy"},     32'(bus.busy), 32'(e_busy));
        check({tag, ".stall"},    32'(bus.stall_MEM), 32'(e_busy));
        check({tag, ".mem_rd"},   32'(bus.mem_rd), 32'(e_rd));
        check({tag, ".mem_wr"},   32'(bus.mem_wr), 32'(e_wr));
        check({tag, ".done"},     32'(bus.done), 32'(e_done));
        check({tag, ".W_reg"},    32'(bus.out_W_reg), 32'(e_wb));
        check({tag, ".Validity"}, 32'(bus.out_Validity), 32'(e_wb));
        check({tag, ".err"},      32'(bus.err), 32'(exp_err));
        if (e_busy) begin
            check({tag, ".mem_addr"},   32'(bus.mem_addr), 32'(e_addr));
            check({tag, ".sm_reg_sel"}, 32'(bus.sm_reg_sel), 32'(e_sel));
        end
        if (e_wb) check({tag, ".RDest"}, 32'(bus.out_RDest), 32'(e_rdest));
    endtask

    // One LM/SM instruction: element k lives at base+k, waits w_k cycles for
    // mem_ready, and its LM writeback shows up in the first cycle of element k+1.
    task automatic apply_stimulus(input string tag, input logic [1:0] op, input logic [7:0] mask,
                                  input logic [15:0] base, input int flush_k,
                                  input int wmin, input int wmax);
        int   idx[$];
        int   w;
        bit   flushed;
        logic lm;
        lm = (op == OP_LM);
        flushed = 1'b0;
        for (int i = 0; i < 8; i++) if (mask[i]) idx.push_back(i);

        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_mask   = mask;
        bus.in_base   = base;
        bus.in_flush  = 1'b0;
        bus.mem_ready = 1'($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0;

        if (idx.size() == 0) begin
            check_output({tag, ".zero"}, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b1, 1'b0, 3'd0);
        end else begin
            exp_err = 1'b0;
            for (int k = 0; k < idx.size(); k++) begin
                w = $urandom_range(wmax, wmin);
                for (int c = 0; c <= w; c++) begin
                    check_output($sformatf("%s.e%0d.c%0d", tag, k, c), 1'b1, lm, !lm,
                                 base + 16'(k), 3'(idx[k]), 1'b0,
                                 (c == 0 && k > 0 && lm), 3'(k > 0 ? idx[k-1] : 0));
                    bus.in_valid  = 1'($urandom);
                    bus.in_op     = 2'($urandom);
                    bus.in_mask   = 8'($urandom);
                    bus.mem_ready = (c == w);
                    if (k == flush_k && c == w) begin
                        bus.in_flush = 1'b1;
                        flushed = 1'b1;
                    end
                    @(negedge clk);
                end
                if (flushed) break;
            end
            bus.in_valid  = 1'b0;
            bus.in_flush  = 1'b0;
            bus.mem_ready = 1'b0;
            if (flushed)
                check_output({tag, ".flushed"}, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd0);
            else
                check_output({tag, ".done"}, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b1, lm,
                             3'(idx[idx.size()-1]));
        end
        @(negedge clk);
        check_output({tag, ".after"}, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [7:0]  mask;
        int          fk;

        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_mask   = 8'h00;
        bus.in_base   = 16'h0000;
        bus.in_flush  = 1'b0;
        bus.mem_ready = 1'b0;

        @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        apply_stimulus("lm05",  OP_LM, 8'h05, 16'h0040, -1, 0, 0);
        apply_stimulus("sm81",  OP_SM, 8'h81, 16'hFFFF, -1, 0, 0);
        apply_stimulus("lmwait", OP_LM, 8'h01, 16'h1000, -1, 3, 3);
        apply_stimulus("lmflush", OP_LM, 8'hFF, 16'h2000, 2, 0, 0);

        // Stuck mem_ready: 255 stalled cycles, then a silent abort with err set.
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_LM;
        bus.in_mask   = 8'h24;
        bus.in_base   = 16'h1234;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 255; i++) begin
            check_output($sformatf("timeout.w%0d", i), 1'b1, 1'b1, 1'b0, 16'h1234, 3'd2,
                         1'b0, 1'b0, 3'd0);
            @(negedge clk);
        end
        exp_err = 1'b1;
        check_output("timeout.abort", 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        check_output("timeout.sticky", 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 3'd0);
        apply_stimulus("errclear", OP_LM, 8'h03, 16'h0100, -1, 0, 1);

        // Asynchronous reset in the middle of an access.
        bus.in_valid  = 1'b1;
        bus.in_op     = OP_LM;
        bus.in_mask   = 8'hFF;
        bus.in_base   = 16'h5555;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_output("midrst.pre", 1'b1, 1'b1, 1'b0, 16'h5555, 3'd0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_all_zero("midrst");
        exp_err = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus("rstzero", OP_LM, 8'h00, 16'h0000, -1, 0, 0);

        for (int t = 0; t < 40; t++) begin
            bus.in_valid  = 1'b1;
            bus.in_op     = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
            bus.in_mask   = 8'($urandom);
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            bus.in_valid = 1'b0;
            check_output($sformatf("rand%0d.noop", t), 1'b0, 1'b0, 1'b0, 16'h0, 3'd0,
                         1'b0, 1'b0, 3'd0);
            op   = ($urandom_range(1, 0) == 1) ? OP_LM : OP_SM;
            mask = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            fk   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
            apply_stimulus($sformatf("rand%0d", t), op, mask, 16'($urandom), fk, 0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lmsm_mem_sequencer.md
Name: lmsm_mem_sequencer

Overview:
- Sequences multi-register load/store (LM/SM) operations in the MEM stage.
- Walks an 8-bit register mask and issues one data-memory access per set bit at consecutive addresses.
- Holds the MEM/WB pipeline register via stall_MEM while the sequence runs.
- Feeds per-register writeback information (RDest, W_reg, validity) to the MEM/WB register.

Parameters:
- ADDR_W, 16, data-memory address width.
- NREG, 8, mask width and register-file size (RDest width = 3).
- MAX_WAIT, 255, cycles without mem_ready before abort; counter width 8.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM-stage instruction valid.
- in_op  in  2  00 = not LM/SM, 01 = LM, 10 = SM, 11 = reserved (treated as 00).
- in_mask  in  8  register mask; bit i selects register i.
- in_base  in  16  start address.
- in_flush  in  1  abort the current sequence (branch misprediction).
- mem_ready  in  1  memory completes the access this cycle.
- mem_addr  out  16  access address.
- mem_rd  out  1  read strobe (LM).
- mem_wr  out  1  write strobe (SM).
- sm_reg_sel  out  3  register whose data the datapath drives to memory (SM).
- out_RDest  out  3  writeback destination.
- out_W_reg  out  1  writeback enable.
- out_Validity  out  1  per-element valid to MEM/WB.
- stall_MEM  out  1  holds upstream stages and MEM/WB.
- busy  out  1  high in ACCESS.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered and update on the rising edge of clk.
- resetn low, asynchronously: state IDLE; all outputs and internal mask/address/counter registers are 0. This applies mid-sequence too: the access is dropped and no done pulse is produced.
- States:
  - IDLE: strobes 0, stall_MEM 0.
  - ACCESS: strobes and stall_MEM asserted.
- IDLE, start: in_valid=1, in_op is LM or SM, in_mask≠0, in_flush=0.
  - Latch mask, address = in_base, op.
  - Next cycle: state ACCESS, busy=1, stall_MEM=1, mem_addr=in_base.
  - mem_rd=1 (LM) or mem_wr=1 (SM).
  - sm_reg_sel = index of the lowest set mask bit.
  - err cleared.
- IDLE, zero mask: in_valid=1, LM/SM, in_mask=0 → done=1 for one cycle; no access, no stall.
- IDLE, other inputs: in_op 00/11 and mem_ready are ignored.
- ACCESS, mem_ready=1 at the edge: the element completes.
  - Clear the lowest set mask bit.
  - Address increments by 1, wrapping 0xFFFF→0x0000.
  - Wait counter resets.
  - LM only: next cycle out_Validity=1, out_W_reg=1, out_RDest = completed index. SM: these stay 0.
  - If remaining mask≠0, stay in ACCESS with updated mem_addr/sm_reg_sel.
  - Otherwise go to IDLE: strobes 0, stall_MEM 0, busy 0, done=1 for one cycle. The final LM writeback appears in the same cycle as done.
- Latency: N set bits with mem_ready held high give N stalled cycles; done follows in cycle N+1 after start.
- ACCESS, mem_ready=0: all outputs hold; wait counter increments.
  - When the counter reaches MAX_WAIT: go to IDLE, err=1 (sticky until the next accepted start), done=0, no writeback.
- in_flush=1 in ACCESS: takes priority over mem_ready on the same edge. The element is discarded, state goes to IDLE, outputs clear, no done, no writeback.
- in_valid while in ACCESS: ignored (upstream is frozen by stall_MEM).
- out_Validity/out_W_reg are 0 in every cycle except LM completion cycles; out_RDest holds its last value otherwise.
- mem_rd and mem_wr are never both 1.

Test Plan:
- LM, mask 0x05, base 0x0040, mem_ready=1:
  - cycles 1–2: mem_addr 0x0040/0x0041, mem_rd=1, stall_MEM=1.
  - writebacks RDest 0 then 2, each with W_reg=1.
  - done pulse in cycle 3; stall low in cycle 3.
- SM, mask 0x81, base 0xFFFF:
  - sm_reg_sel 0 at addr 0xFFFF, then 7 at 0x0000 (wrap).
  - mem_wr=1, out_W_reg never 1, done after 2 accesses.
- LM mask 0x01, mem_ready low 3 cycles then high:
  - mem_addr and mem_rd held for 4 cycles, stall_MEM high 4 cycles.
  - single writeback RDest 0, then done.
- LM mask 0xFF with in_flush at the 3rd access edge while mem_ready=1:
  - only 2 writebacks (RDest 0, 1); IDLE next cycle; done never asserted.
- mem_ready stuck low:
  - after 255 wait cycles, err=1, stall_MEM=0, state IDLE.
  - the next LM start clears err.
- resetn pulsed low mid-ACCESS, asynchronous to clk:
  - all outputs 0 immediately; after release, an LM mask 0x00 gives a done pulse with no strobes.
